// File: rtl/bcd_counter_sync_if.sv
// Control and data bundle between a BCD counter and its user.
// The user drives the master side; the counter implements the slave side.
interface bcd_counter_sync_if #(
    parameter int DIGITS = 4
);
    logic                en;
    logic                up_dn;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] q;
    logic                tc;

    modport master (output en, up_dn, load, load_val, input q, tc);
    modport slave  (input en, up_dn, load, load_val, output q, tc);
endinterface

// File: rtl/bcd_counter_sync.sv
// Multi-digit synchronous BCD up/down counter with prescaler, parallel load and terminal-count pulse.
// Define BCD_CNT_SAT_EN to make the counter saturate at its limits instead of wrapping.
module bcd_counter_sync #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int PRE_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_counter_sync_if.slave bus
);
    localparam int QW = 4 * DIGITS;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [QW-1:0]    cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic [QW:0]      stepped;

    function automatic logic [QW-1:0] clamp_bcd(input logic [QW-1:0] v);
        logic [QW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple carry/borrow across digits; the MSB of the result is the wrap flag.
    function automatic logic [QW:0] bcd_step(input logic [QW-1:0] v, input logic up);
        logic [QW-1:0] r;
        logic          c;
        logic [3:0]    d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin d = d + 4'd1; c = 1'b0; end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin d = d - 4'd1; c = 1'b0; end
                end
            end
            r[4*i +: 4] = d;
        end
        return {c, r};
    endfunction

    assign tick    = bus.en && (pre_q == PRE_W'(PRESCALE - 1));
    assign stepped = bcd_step(cnt_q, bus.up_dn);

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            cnt_d = clamp_bcd(bus.load_val);
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
            tc_d  = stepped[QW];
`ifdef BCD_CNT_SAT_EN
            if (!stepped[QW]) cnt_d = stepped[QW-1:0];
`else
            cnt_d = stepped[QW-1:0];
`endif
        end else if (bus.en) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.q  = cnt_q;
    assign bus.tc = tc_q;
endmodule
